// File: rtl/tdoa_pkg.sv
// rtl/tdoa_pkg.sv - shared types, defaults and width helper for the TDOA collector
package tdoa_pkg;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_COMPUTE = 2'd2,
    S_OUTPUT  = 2'd3
  } state_t;

  localparam int TW_DEFAULT = 32;

  // Width of an index/counter able to hold 0..n-1; never narrower than one bit.
  function automatic int cw(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/tdoa_capture_slot.sv
// rtl/tdoa_capture_slot.sv - per-channel timestamp latch, mask bit and one-cycle ack
module tdoa_capture_slot
  import tdoa_pkg::*;
#(
  parameter int TW = TW_DEFAULT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cap_en,
  input  logic          clear,
  input  logic          ts_valid,
  input  logic [TW-1:0] ts_in,
  output logic          cand,
  output logic          mask,
  output logic          ack,
  output logic [TW-1:0] ts_out
);

  logic          mask_q, mask_d;
  logic          ack_q, ack_d;
  logic [TW-1:0] ts_q, ts_d;
  logic          capture;

  // A masked channel stays pending until the collector clears the event.
  assign cand = ts_valid & ~mask_q;

  always_comb begin
    capture = cap_en & cand;
    ack_d   = capture;
    ts_d    = capture ? ts_in : ts_q;
    mask_d  = clear ? 1'b0 : (mask_q | capture);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mask_q <= 1'b0;
      ack_q  <= 1'b0;
      ts_q   <= '0;
    end else begin
      mask_q <= mask_d;
      ack_q  <= ack_d;
      ts_q   <= ts_d;
    end
  end

  assign mask   = mask_q;
  assign ack    = ack_q;
  assign ts_out = ts_q;

endmodule

// File: rtl/tdoa_collector.sv
// rtl/tdoa_collector.sv - groups per-mic timestamps into one event and emits deltas vs channel 0
module tdoa_collector
  import tdoa_pkg::*;
#(
  parameter int NCH    = 4,
  parameter int TW     = TW_DEFAULT,
  parameter int WINDOW = 4096
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NCH*TW-1:0]       ts_data,
  input  logic [NCH-1:0]          ts_valid,
  output logic [NCH-1:0]          ts_ack,
  output logic [(NCH-1)*TW-1:0]   delta_out,
  output logic [cw(NCH)-1:0]      first_ch,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    timeout,
  output logic                    busy
);

  localparam int CHW  = cw(NCH);
  localparam int CNTW = cw(WINDOW);

  state_t                  state_q, state_d;
  logic [CNTW-1:0]         cnt_q, cnt_d;
  logic [CHW-1:0]          first_ch_q, first_ch_d;
  logic [(NCH-1)*TW-1:0]   delta_q, delta_d;
  logic                    out_valid_q, out_valid_d;
  logic                    timeout_q, timeout_d;

  logic                    cap_en;
  logic                    clear;
  logic [NCH-1:0]          cand;
  logic [NCH-1:0]          mask;
  logic [TW-1:0]           ts_reg [NCH];
  logic                    full_next;
  logic                    any_cand;
  logic [CHW-1:0]          low_idx;

  for (genvar i = 0; i < NCH; i++) begin : g_slot
    tdoa_capture_slot #(.TW(TW)) u_slot (
      .clk      (clk),
      .rst      (rst),
      .cap_en   (cap_en),
      .clear    (clear),
      .ts_valid (ts_valid[i]),
      .ts_in    (ts_data[i*TW +: TW]),
      .cand     (cand[i]),
      .mask     (mask[i]),
      .ack      (ts_ack[i]),
      .ts_out   (ts_reg[i])
    );
  end

  // Whether the mask would be full if every pending channel captured this edge.
  assign full_next = &(mask | cand);
  assign any_cand  = |cand;

  always_comb begin
    low_idx = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (cand[i]) low_idx = CHW'(i);
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    first_ch_d  = first_ch_q;
    delta_d     = delta_q;
    out_valid_d = out_valid_q;
    timeout_d   = 1'b0;
    cap_en      = 1'b0;
    clear       = 1'b0;

    case (state_q)
      S_IDLE: begin
        cap_en = 1'b1;
        if (any_cand) begin
          first_ch_d = low_idx;
          cnt_d      = '0;
          state_d    = full_next ? S_COMPUTE : S_COLLECT;
        end
      end

      S_COLLECT: begin
        cap_en = 1'b1;
        cnt_d  = cnt_q + 1'b1;
        if (full_next) begin
          state_d = S_COMPUTE;
        end else if (cnt_q == CNTW'(WINDOW - 1)) begin
          // Window expired: partial captures on this edge are refused, not acked.
          cap_en    = 1'b0;
          clear     = 1'b1;
          timeout_d = 1'b1;
          cnt_d     = '0;
          state_d   = S_IDLE;
        end
      end

      S_COMPUTE: begin
        for (int k = 1; k < NCH; k++) begin
          delta_d[(k-1)*TW +: TW] = ts_reg[k] - ts_reg[0];
        end
        state_d = S_OUTPUT;
      end

      S_OUTPUT: begin
        out_valid_d = 1'b1;
        if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
          clear       = 1'b1;
          state_d     = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      first_ch_q  <= '0;
      delta_q     <= '0;
      out_valid_q <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      first_ch_q  <= first_ch_d;
      delta_q     <= delta_d;
      out_valid_q <= out_valid_d;
      timeout_q   <= timeout_d;
    end
  end

  assign delta_out = delta_q;
  assign first_ch  = first_ch_q;
  assign out_valid = out_valid_q;
  assign timeout   = timeout_q;
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_tdoa_collector.sv
// tb/tb_tdoa_collector.sv - self-checking bench for tdoa_collector
module tb_tdoa_collector;

  localparam int NCH    = 4;
  localparam int TW     = 32;
  localparam int WINDOW = 64;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NCH*TW-1:0]     ts_data;
  logic [NCH-1:0]        ts_valid;
  logic [NCH-1:0]        ts_ack;
  logic [(NCH-1)*TW-1:0] delta_out;
  logic [1:0]            first_ch;
  logic                  out_valid;
  logic                  out_ready;
  logic                  timeout;
  logic                  busy;

  always #5 clk = ~clk;

  tdoa_collector #(.NCH(NCH), .TW(TW), .WINDOW(WINDOW)) dut (
    .clk       (clk),
    .rst       (rst),
    .ts_data   (ts_data),
    .ts_valid  (ts_valid),
    .ts_ack    (ts_ack),
    .delta_out (delta_out),
    .first_ch  (first_ch),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .timeout   (timeout),
    .busy      (busy)
  );

  typedef struct {
    logic [95:0] delta;
    logic [1:0]  first;
  } rec_t;

  typedef struct {
    logic [3:0][31:0] ts;
    logic [3:0][7:0]  dly;
    logic [95:0]      delta;
    logic [1:0]       first;
  } vec_t;

  rec_t sb[$];
  vec_t vecs[4];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int ack_cnt[NCH];
  int last_ack_cyc[NCH];
  int to_cnt = 0;
  int to_cyc = 0;
  int ov_cnt = 0;
  int ov_rise = 0;
  int last_hs = 0;
  logic ov_prev = 1'b0;
  logic [NCH-1:0] ack_prev = '0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic push_exp(input logic [95:0] d, input logic [1:0] f);
    rec_t r;
    r.delta = d;
    r.first = f;
    sb.push_back(r);
  endtask

  // One clock: score a record on its handshake edge, then model the Timer sources.
  task automatic tick();
    logic hs;
    rec_t r;
    hs = out_valid && out_ready;
    if (hs) begin
      if (sb.size() == 0) begin
        chk("unexpected_record", 1, 0);
      end else begin
        r = sb.pop_front();
        chk("delta_out", delta_out, r.delta);
        chk("first_ch", first_ch, r.first);
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    if (hs) last_hs = cyc;
    for (int i = 0; i < NCH; i++) begin
      if (ts_ack[i]) begin
        chk("ack_single_pulse", ack_prev[i], 0);
        ack_cnt[i]++;
        last_ack_cyc[i] = cyc;
        ts_valid[i] = 1'b0;
      end
    end
    ack_prev = ts_ack;
    if (timeout) begin
      to_cnt++;
      to_cyc = cyc;
    end
    if (out_valid && !ov_prev) begin
      ov_rise = cyc;
      ov_cnt++;
    end
    ov_prev = out_valid;
  endtask

  task automatic raise(input int ch, input logic [31:0] val);
    ts_data[ch*TW +: TW] = val;
    ts_valid[ch] = 1'b1;
  endtask

  task automatic clear_acks();
    for (int i = 0; i < NCH; i++) ack_cnt[i] = 0;
  endtask

  task automatic wait_idle();
    bit done;
    done = 0;
    for (int n = 0; n < 300 && !done; n++) begin
      if (sb.size() == 0 && !busy && !out_valid) done = 1;
      else tick();
    end
    if (!done) chk("drain_bound", 0, 1);
  endtask

  task automatic run_vec(input vec_t v);
    int maxd;
    int lastcap;
    clear_acks();
    push_exp(v.delta, v.first);
    maxd = 0;
    for (int i = 0; i < NCH; i++) if (int'(v.dly[i]) > maxd) maxd = int'(v.dly[i]);
    for (int t = 0; t <= maxd; t++) begin
      for (int i = 0; i < NCH; i++) if (int'(v.dly[i]) == t) raise(i, v.ts[i]);
      tick();
    end
    wait_idle();
    lastcap = 0;
    for (int i = 0; i < NCH; i++) begin
      chk("ack_count", ack_cnt[i], 1);
      if (last_ack_cyc[i] > lastcap) lastcap = last_ack_cyc[i];
    end
    chk("out_valid_latency", ov_rise - lastcap, 2);
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_ts_ack"}, ts_ack, 0);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_timeout"}, timeout, 0);
    chk({tag, "_delta_out"}, delta_out, 0);
    chk({tag, "_first_ch"}, first_ch, 0);
    chk({tag, "_busy"}, busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_time_limit");
    $fatal(1);
  end

  initial begin
    logic [95:0] snap_d;
    logic [1:0]  snap_f;
    bit          stable;
    int          c0;

    vecs[0].ts = {32'd1250, 32'd1040, 32'd1100, 32'd1000};
    vecs[0].dly = {8'd30, 8'd10, 8'd20, 8'd0};
    vecs[0].delta = {32'd250, 32'd40, 32'd100};
    vecs[0].first = 2'd0;
    vecs[1].ts = {32'hFFFF_FFF8, 32'h20, 32'hFFFF_FFF0, 32'h10};
    vecs[1].dly = {8'd7, 8'd6, 8'd0, 8'd5};
    vecs[1].delta = {32'hFFFF_FFE8, 32'h10, 32'hFFFF_FFE0};
    vecs[1].first = 2'd1;
    vecs[2].ts = {32'd501, 32'd499, 32'd500, 32'd500};
    vecs[2].dly = {8'd0, 8'd0, 8'd0, 8'd0};
    vecs[2].delta = {32'd1, 32'hFFFF_FFFF, 32'd0};
    vecs[2].first = 2'd0;
    vecs[3].ts = {32'd40, 32'd30, 32'd20, 32'd10};
    vecs[3].dly = {8'd0, 8'd0, 8'd3, 8'd3};
    vecs[3].delta = {32'd30, 32'd20, 32'd10};
    vecs[3].first = 2'd2;

    for (int i = 0; i < NCH; i++) begin
      ack_cnt[i] = 0;
      last_ack_cyc[i] = 0;
    end
    rst = 1'b1;
    ts_valid = '0;
    ts_data = '0;
    out_ready = 1'b1;
    tick();
    tick();
    chk_zero_outputs("reset");
    rst = 1'b0;
    tick();

    for (int v = 0; v < 4; v++) run_vec(vecs[v]);

    // Timeout: two channels only, then a fresh event led by channel 2.
    clear_acks();
    to_cnt = 0;
    ov_cnt = 0;
    raise(0, 32'd11);
    raise(1, 32'd22);
    tick();
    c0 = last_ack_cyc[0];
    for (int n = 0; n < WINDOW + 4; n++) tick();
    chk("timeout_count", to_cnt, 1);
    chk("timeout_position", (to_cyc - c0 >= WINDOW - 1) && (to_cyc - c0 <= WINDOW), 1);
    chk("timeout_no_record", ov_cnt, 0);
    chk("timeout_idle", busy, 0);
    chk("timeout_acks", {ack_cnt[0][7:0], ack_cnt[1][7:0]}, 16'h0101);
    push_exp({32'd210, 32'd200, 32'd100}, 2'd2);
    raise(2, 32'd300);
    tick();
    tick();
    raise(3, 32'd310);
    raise(0, 32'd100);
    raise(1, 32'd200);
    tick();
    wait_idle();
    chk("post_timeout_no_timeout", to_cnt, 1);

    // Backpressure: record held while channel 0 re-asserts valid.
    clear_acks();
    out_ready = 1'b0;
    push_exp({32'd7, 32'd6, 32'd5}, 2'd0);
    raise(0, 32'd0);
    raise(1, 32'd5);
    raise(2, 32'd6);
    raise(3, 32'd7);
    for (int n = 0; n < 10 && !out_valid; n++) tick();
    chk("bp_out_valid", out_valid, 1);
    snap_d = delta_out;
    snap_f = first_ch;
    raise(0, 32'd999);
    stable = 1;
    for (int n = 0; n < 50; n++) begin
      tick();
      if (delta_out !== snap_d || first_ch !== snap_f || out_valid !== 1'b1) stable = 0;
    end
    chk("bp_outputs_stable", stable, 1);
    chk("bp_no_reack", ack_cnt[0], 1);
    chk("bp_valid_pending", ts_valid[0], 1);
    push_exp({32'd0, 32'hFFFF_FFF6, 32'd10}, 2'd0);
    out_ready = 1'b1;
    tick();
    for (int n = 0; n < 10 && ack_cnt[0] < 2; n++) tick();
    chk("bp_ack_after_idle", last_ack_cyc[0] - last_hs, 1);
    raise(1, 32'd1009);
    raise(2, 32'd989);
    raise(3, 32'd999);
    tick();
    wait_idle();

    // Reset in the middle of a partial event led by channel 2.
    to_cnt = 0;
    raise(2, 32'd50);
    tick();
    tick();
    raise(3, 32'd60);
    tick();
    tick();
    chk("rst_mid_busy", busy, 1);
    rst = 1'b1;
    tick();
    chk_zero_outputs("rst_mid");
    rst = 1'b0;
    for (int n = 0; n < WINDOW + 4; n++) tick();
    chk("rst_mid_no_timeout", to_cnt, 0);
    clear_acks();
    push_exp({32'd3, 32'd2, 32'd1}, 2'd0);
    raise(0, 32'd7);
    raise(1, 32'd8);
    raise(2, 32'd9);
    raise(3, 32'd10);
    tick();
    wait_idle();
    chk("rst_fresh_acks", {ack_cnt[0][3:0], ack_cnt[1][3:0], ack_cnt[2][3:0], ack_cnt[3][3:0]}, 16'h1111);

    chk("scoreboard_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
